// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the byte-serialising two-port memory arbiter.
package mem_arb_pkg;
    localparam int DEF_ADDR_W     = 12;
    localparam int DEF_WORD_BYTES = 8;
    localparam int MEM_BYTES      = 1 << DEF_ADDR_W;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_XFER  = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Owner value doubles as the bit index of the one-hot grant vector.
    typedef enum logic {OWN_F = 1'b0, OWN_D = 1'b1} owner_t;
endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-way round-robin arbiter: on a tie the port that did not win last time wins.
module mem_rr_arbiter
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req_f,
    input  logic       i_req_d,
    input  logic       i_en,
    output logic [1:0] o_grant
);
    owner_t r_last;

    always_comb begin
        o_grant = 2'b00;
        if (i_en) begin
            if (i_req_f && i_req_d)
                o_grant = (r_last == OWN_F) ? 2'b10 : 2'b01;
            else
                o_grant = {i_req_d, i_req_f};
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_last <= OWN_F;
        else if (o_grant[1])
            r_last <= OWN_D;
        else if (o_grant[0])
            r_last <= OWN_F;
    end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a read-only fetch port and a read/write data port onto a byte-wide
// synchronous RAM, moving one big-endian word per grant one byte per cycle.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int WORD_BYTES = DEF_WORD_BYTES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    f_req,
    input  logic [ADDR_W-1:0]       f_addr,
    output logic                    f_ack,
    output logic                    f_err,
    output logic [8*WORD_BYTES-1:0] f_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_W-1:0]       d_addr,
    input  logic [8*WORD_BYTES-1:0] d_wdata,
    output logic                    d_ack,
    output logic                    d_err,
    output logic [8*WORD_BYTES-1:0] d_rdata,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_we,
    output logic [7:0]              mem_wdata,
    input  logic [7:0]              mem_rdata,
    output logic                    busy
);
    localparam int WBITS = 8 * WORD_BYTES;
    localparam int CNT_W = $clog2(WORD_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_BYTES - 1);
    localparam logic [ADDR_W:0]  LAST_OFS = (ADDR_W + 1)'(WORD_BYTES - 1);

    state_t             r_state;
    owner_t             r_owner;
    logic               r_we;
    logic               r_err;
    logic [CNT_W-1:0]   r_cnt;
    logic [WBITS-1:0]   r_wdata;
    logic [WBITS-1:0]   r_shift;
    logic [WBITS-1:0]   r_f_rdata;
    logic [WBITS-1:0]   r_d_rdata;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_mem_we;
    logic [7:0]         r_mem_wdata;

    logic [1:0]         w_grant;
    logic [ADDR_W-1:0]  w_addr;
    logic               w_we;
    logic [ADDR_W:0]    w_end;
    logic               w_range_err;

    mem_rr_arbiter u_rr (
        .clk     (clk),
        .rst     (rst),
        .i_req_f (f_req),
        .i_req_d (d_req),
        .i_en    (r_state == ST_IDLE),
        .o_grant (w_grant)
    );

    // The carry out of base + (WORD_BYTES-1) flags a word running past the top.
    assign w_addr      = w_grant[1] ? d_addr : f_addr;
    assign w_we        = w_grant[1] & d_we;
    assign w_end       = {1'b0, w_addr} + LAST_OFS;
    assign w_range_err = w_end[ADDR_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_F;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_wdata     <= '0;
            r_shift     <= '0;
            r_f_rdata   <= '0;
            r_d_rdata   <= '0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_grant) begin
                        r_owner <= w_grant[1] ? OWN_D : OWN_F;
                        r_we    <= w_we;
                        r_err   <= w_range_err;
                        r_cnt   <= '0;
                        if (w_range_err) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state     <= ST_XFER;
                            r_mem_addr  <= w_addr;
                            r_mem_we    <= w_we;
                            r_mem_wdata <= d_wdata[WBITS-1 -: 8];
                            r_wdata     <= d_wdata << 8;
                        end
                    end
                end
                ST_XFER: begin
                    // Byte k-1 returns from the RAM while byte k is being addressed.
                    if (r_cnt != '0)
                        r_shift <= {r_shift[WBITS-9:0], mem_rdata};
                    if (r_cnt == LAST_CNT) begin
                        r_mem_we <= 1'b0;
                        r_state  <= r_we ? ST_DONE : ST_DRAIN;
                    end else begin
                        r_cnt       <= r_cnt + 1'b1;
                        r_mem_addr  <= r_mem_addr + 1'b1;
                        r_mem_wdata <= r_wdata[WBITS-1 -: 8];
                        r_wdata     <= r_wdata << 8;
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_DONE;
                    if (r_owner == OWN_D)
                        r_d_rdata <= {r_shift[WBITS-9:0], mem_rdata};
                    else
                        r_f_rdata <= {r_shift[WBITS-9:0], mem_rdata};
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign f_ack     = (r_state == ST_DONE) && (r_owner == OWN_F);
    assign d_ack     = (r_state == ST_DONE) && (r_owner == OWN_D);
    assign f_err     = f_ack & r_err;
    assign d_err     = d_ack & r_err;
    assign f_rdata   = r_f_rdata;
    assign d_rdata   = r_d_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != ST_IDLE);
endmodule
